// File: rtl/div36x18_pkg.sv
// div36x18_pkg: shared widths, FSM states and saturation limits for the 36/18 divider
package div36x18_pkg;
  localparam int DW = 36;
  localparam int VW = 18;
  localparam int CNT_W = 6;
  localparam logic [VW-1:0] Q_MAX = 18'h1FFFF;
  localparam logic [VW-1:0] Q_MIN = 18'h20000;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
endpackage

// File: rtl/div36x18_step.sv
// div36x18_step: one combinational restoring-division step on magnitudes
module div36x18_step
  import div36x18_pkg::*;
(
  input  logic [VW:0]   pr,
  input  logic          din,
  input  logic [VW-1:0] dvs,
  output logic [VW:0]   pr_nxt,
  output logic          qbit
);
  logic [VW:0] sh;
  assign sh = {pr[VW-1:0], din};
  // pr[VW] is the bit shifted out; if set, the shifted value already exceeds dvs
  assign qbit = pr[VW] | (sh >= {1'b0, dvs});
  assign pr_nxt = qbit ? sh - {1'b0, dvs} : sh;
endmodule

// File: rtl/div36x18_seq.sv
// div36x18_seq: sequential signed 36/18 restoring divider with saturation
// DIV36X18_EARLY_DIV0_EN: a zero divisor skips CALC and completes one cycle after START
module div36x18_seq
  import div36x18_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [DW-1:0] DIVIDEND,
  input  logic [VW-1:0] DIVISOR,
  output logic          BUSY,
  output logic          DONE,
  output logic [VW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          OVF,
  output logic          DIV0
);
  state_t state, nxt, ld_nxt;
  logic [DW-1:0] qd, a_mag;
  logic [VW:0] pr, pr_nxt;
  logic [VW-1:0] dvs, d_lo, b_mag, r_s;
  logic [CNT_W-1:0] cnt;
  logic [DW:0] q_s;
  logic sign_q, sign_r, div0_r, qbit, ovf;
  assign a_mag = DIVIDEND[DW-1] ? -DIVIDEND : DIVIDEND;
  assign b_mag = DIVISOR[VW-1] ? -DIVISOR : DIVISOR;
  assign q_s = sign_q ? -{1'b0, qd} : {1'b0, qd};
  // signed quotient fits in VW bits only if its upper bits are a pure sign extension
  assign ovf = ~(&q_s[DW:VW-1] | ~|q_s[DW:VW-1]);
  assign r_s = sign_r ? -pr[VW-1:0] : pr[VW-1:0];
  assign BUSY = state != IDLE;
`ifdef DIV36X18_EARLY_DIV0_EN
  assign ld_nxt = (DIVISOR == '0) ? FIXUP : CALC;
`else
  assign ld_nxt = CALC;
`endif
  div36x18_step u_step (
    .pr(pr),
    .din(qd[DW-1]),
    .dvs(dvs),
    .pr_nxt(pr_nxt),
    .qbit(qbit)
  );
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = START ? ld_nxt : IDLE;
      CALC: nxt = (cnt == '0) ? FIXUP : CALC;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      DONE <= 1'b0;
      Q <= '0;
      R <= '0;
      OVF <= 1'b0;
      DIV0 <= 1'b0;
    end else begin
      DONE <= state == FIXUP;
      if (state == IDLE && START) begin
        qd <= a_mag;
        pr <= '0;
        dvs <= b_mag;
        cnt <= CNT_W'(DW - 1);
        sign_q <= DIVIDEND[DW-1] ^ DIVISOR[VW-1];
        sign_r <= DIVIDEND[DW-1];
        div0_r <= DIVISOR == '0;
        d_lo <= DIVIDEND[VW-1:0];
      end
      // quotient bits shift in behind the dividend bits as they are consumed
      if (state == CALC) begin
        qd <= {qd[DW-2:0], qbit};
        pr <= pr_nxt;
        cnt <= cnt - 1'b1;
      end
      if (state == FIXUP) begin
        Q <= (div0_r | ovf) ? ((div0_r ? sign_r : sign_q) ? Q_MIN : Q_MAX) : q_s[VW-1:0];
        R <= div0_r ? d_lo : r_s;
        OVF <= ~div0_r & ovf;
        DIV0 <= div0_r;
      end
    end
  end
endmodule

// File: tb/tb_div36x18_seq.sv
// tb_div36x18_seq: self-checking bench for div36x18_seq, directed and randomized
module tb_div36x18_seq;
  logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
  logic [35:0] DIVIDEND = '0;
  logic [17:0] DIVISOR = '0;
  logic BUSY, DONE, OVF, DIV0;
  logic [17:0] Q, R;
  int total = 0, bad = 0;
`ifdef DIV36X18_EARLY_DIV0_EN
  localparam int LAT0 = 1;
`else
  localparam int LAT0 = 37;
`endif
  typedef struct {logic [35:0] d; logic [17:0] v, q, r; logic o;} vec_t;
  always #5 CLK = ~CLK;
  div36x18_seq dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
    .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .OVF(OVF), .DIV0(DIV0)
  );
  function automatic logic [37:0] model(input logic [35:0] d, input logic [17:0] v);
    longint a, b, q, r;
    logic [17:0] qq;
    a = longint'($signed(d));
    b = longint'($signed(v));
    if (b == 0) return {(a < 0) ? 18'h20000 : 18'h1FFFF, d[17:0], 1'b0, 1'b1};
    q = a / b;
    r = a % b;
    qq = (q > 131071) ? 18'h1FFFF : (q < -131072) ? 18'h20000 : q[17:0];
    return {qq, r[17:0], (q > 131071 || q < -131072), 1'b0};
  endfunction
  task automatic start_op(input logic [35:0] d, input logic [17:0] v);
    DIVIDEND = d;
    DIVISOR = v;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    DIVIDEND = 36'($urandom);
    DIVISOR = 18'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!DONE && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    if (!DONE) lat = -1;
  endtask
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({BUSY, DONE, Q, R, OVF, DIV0} !== 39'd0) begin
      bad++;
      $display("FAIL reset: busy/done/q/r/ovf/div0 got %b/%b/%h/%h/%b/%b want all zero", BUSY, DONE, Q, R, OVF, DIV0);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask
  task automatic test_directed();
    vec_t t[11];
    int lat;
    t = '{
      '{36'd1000, 18'd7, 18'd142, 18'd6, 1'b0},
      '{-36'sd1000, 18'd7, 18'h3FF72, 18'h3FFFA, 1'b0},
      '{36'd1000, 18'h3FFF9, 18'h3FF72, 18'd6, 1'b0},
      '{36'h000100000, 18'd1, 18'h1FFFF, 18'd0, 1'b1},
      '{36'h800000000, 18'h3FFFF, 18'h1FFFF, 18'd0, 1'b1},
      '{36'hFFFF00000, 18'd1, 18'h20000, 18'd0, 1'b1},
      '{36'd131071, 18'd1, 18'h1FFFF, 18'd0, 1'b0},
      '{36'hFFFFE0000, 18'd1, 18'h20000, 18'd0, 1'b0},
      '{36'd131072, 18'd1, 18'h1FFFF, 18'd0, 1'b1},
      '{36'hFFFFDFFFF, 18'd1, 18'h20000, 18'd0, 1'b1},
      '{36'h7FFFFFFFF, 18'h1FFFF, 18'h1FFFF, 18'd1, 1'b1}
    };
    for (int i = 0; i < 11; i++) begin
      start_op(t[i].d, t[i].v);
      total++;
      if (BUSY !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_busy: got %b want 1", i, BUSY);
      end
      wait_done(lat);
      total++;
      if (lat !== 37) begin
        bad++;
        $display("FAIL dir%0d_latency: got %0d want 37", i, lat);
      end
      total++;
      if ({Q, R, OVF, DIV0} !== {t[i].q, t[i].r, t[i].o, 1'b0}) begin
        bad++;
        $display("FAIL dir%0d_result: q/r/ovf/div0 got %h/%h/%b/%b want %h/%h/%b/0", i, Q, R, OVF, DIV0, t[i].q, t[i].r, t[i].o);
      end
      total++;
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_pulse: done/busy got %b/%b want 0/0", i, DONE, BUSY);
      end
    end
  endtask
  task automatic test_div0();
    logic [35:0] ds[3];
    logic [17:0] eq[3], er[3];
    int lat;
    ds = '{36'd5, -36'sd5, 36'h000100005};
    eq = '{18'h1FFFF, 18'h20000, 18'h1FFFF};
    er = '{18'd5, 18'h3FFFB, 18'd5};
    for (int i = 0; i < 3; i++) begin
      start_op(ds[i], 18'd0);
      wait_done(lat);
      total++;
      if (lat !== LAT0) begin
        bad++;
        $display("FAIL div0_%0d_latency: got %0d want %0d", i, lat, LAT0);
      end
      total++;
      if ({Q, R, OVF, DIV0} !== {eq[i], er[i], 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL div0_%0d_result: q/r/ovf/div0 got %h/%h/%b/%b want %h/%h/0/1", i, Q, R, OVF, DIV0, eq[i], er[i]);
      end
    end
  endtask
  task automatic test_random();
    logic [35:0] d;
    logic [17:0] v;
    logic [37:0] exp;
    int lat;
    for (int i = 0; i < 60; i++) begin
      d = {4'($urandom), 32'($urandom)} >> $urandom_range(0, 35);
      v = 18'($urandom) >> $urandom_range(0, 17);
      if ($urandom_range(0, 1) == 1) d = -d;
      if ($urandom_range(0, 1) == 1) v = -v;
      exp = model(d, v);
      start_op(d, v);
      wait_done(lat);
      total++;
      if (lat !== ((v == 0) ? LAT0 : 37)) begin
        bad++;
        $display("FAIL rand%0d_latency: got %0d for %h/%h", i, lat, d, v);
      end
      total++;
      if ({Q, R, OVF, DIV0} !== exp) begin
        bad++;
        $display("FAIL rand%0d_result: %h/%h q/r/ovf/div0 got %h/%h/%b/%b want %h/%h/%b/%b", i, d, v, Q, R, OVF, DIV0, exp[37:20], exp[19:2], exp[1], exp[0]);
      end
    end
  endtask
  task automatic test_abort();
    int lat, seen;
    start_op(36'd1000, 18'd7);
    repeat (9) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    total++;
    if ({BUSY, DONE, Q, R, OVF, DIV0} !== 39'd0) begin
      bad++;
      $display("FAIL abort_reset: busy/done/q/r/ovf/div0 got %b/%b/%h/%h/%b/%b want all zero", BUSY, DONE, Q, R, OVF, DIV0);
    end
    RST_N = 1'b1;
    seen = 0;
    repeat (45) begin
      @(posedge CLK); #1;
      if (DONE) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d pulses want 0", seen);
    end
    start_op(36'd100, 18'd10);
    wait_done(lat);
    total++;
    if (lat !== 37 || {Q, R, OVF, DIV0} !== {18'd10, 18'd0, 2'b00}) begin
      bad++;
      $display("FAIL abort_restart: lat/q/r got %0d/%h/%h want 37/00000a/00000", lat, Q, R);
    end
  endtask
  task automatic test_back_to_back();
    int lat, seen;
    start_op(36'd1000, 18'd7);
    repeat (5) @(posedge CLK);
    #1;
    DIVIDEND = 36'd999;
    DIVISOR = 18'd3;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(lat);
    total++;
    if (lat + 6 !== 37 || {Q, R} !== {18'd142, 18'd6}) begin
      bad++;
      $display("FAIL b2b_ignored_start: lat/q/r got %0d/%h/%h want 37/0008e/00006", lat + 6, Q, R);
    end
    start_op(36'd36, 18'd6);
    total++;
    if (BUSY !== 1'b1 || Q !== 18'd142 || R !== 18'd6) begin
      bad++;
      $display("FAIL b2b_accept_hold: busy/q/r got %b/%h/%h want 1/0008e/00006", BUSY, Q, R);
    end
    wait_done(lat);
    total++;
    if (lat !== 37 || {Q, R, OVF, DIV0} !== {18'd6, 18'd0, 2'b00}) begin
      bad++;
      $display("FAIL b2b_second: lat/q/r got %0d/%h/%h want 37/00006/00000", lat, Q, R);
    end
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL b2b_not_queued: got %0d busy/done cycles want 0", seen);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_div0();
    test_random();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
